pipe_mux_tree: RTL and testbench

- Parametrised, pipelined N_IN:1 multiplexer of WIDTH-bit words. Built as a tree of 4:1 levels with one register stage per level.
- Uses a valid/ready handshake so it can sit on a stallable datapath, e.g. a register-file read port or forwarding select in the pipelined CPU.
- Successor to the single-bit combinational 16:1 mux: adds word width, generic depth, throughput pipelining and backpressure.

---
 rtl/cpu_mux_pkg.sv | 23 ++
 rtl/pipe_mux_tree_mux4_w.sv | 16 +
 rtl/pipe_mux_tree.sv | 93 +++++++++
 tb/tb_pipe_mux_tree.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mux_pkg.sv
// Elaboration-time helpers for the pipelined mux tree: base-4 log and power-of-4 test.
package cpu_mux_pkg;

  function automatic int clog4(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 4;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow4(input int n);
    int v;
    v = 1;
    while (v < n) v = v * 4;
    return (v == n);
  endfunction

endpackage

// File: rtl/pipe_mux_tree_mux4_w.sv
// Combinational WIDTH-bit 4:1 mux; sel1:sel0 = 00..11 picks i00..i11. Zero latency, no flow control.
module mux4_w #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] i00,
  input  logic [WIDTH-1:0] i01,
  input  logic [WIDTH-1:0] i10,
  input  logic [WIDTH-1:0] i11,
  input  logic             sel0,
  input  logic             sel1
);

  assign out = sel1 ? (sel0 ? i11 : i10) : (sel0 ? i01 : i00);

endmodule

// File: rtl/pipe_mux_tree.sv
// Pipelined N_IN:1 word mux built from 4:1 levels, one register stage per level; latency LEVELS cycles.
// Per-stage elastic valid/ready: a stage loads when empty or when its successor loads; stalled stages hold.
module pipe_mux_tree
  import cpu_mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int N_IN   = 16,
  localparam int LEVELS = clog4(N_IN)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_IN*WIDTH-1:0]  in_data,
  input  logic [2*LEVELS-1:0]    in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  if (N_IN < 4 || !is_pow4(N_IN)) begin : g_bad_n_in
    $error("pipe_mux_tree: N_IN=%0d must be a power of 4 and at least 4", N_IN);
  end

  for (genvar j = 0; j < LEVELS; j++) begin : lvl
    localparam int NI = N_IN >> (2 * j);
    localparam int NO = NI / 4;
    localparam int RS = 2 * (LEVELS - j);

    logic                  v_in;
    logic [NI*WIDTH-1:0]   d_in;
    logic [RS-1:0]         s_in;
    logic [NO*WIDTH-1:0]   d_mux;
    logic [NO*WIDTH-1:0]   d_q;
    logic                  v_q;
    logic                  nxt;
    logic                  load;

    if (j == 0) begin : g_src
      assign v_in = in_valid;
      assign d_in = in_data;
      assign s_in = in_sel;
    end else begin : g_src
      assign v_in = lvl[j-1].v_q;
      assign d_in = lvl[j-1].d_q;
      assign s_in = lvl[j-1].g_sel.s_q;
    end

    // The ready chain ripples combinationally from out_ready back to in_ready.
    if (j == LEVELS - 1) begin : g_nxt
      assign nxt = out_ready;
    end else begin : g_nxt
      assign nxt = lvl[j+1].load;
    end
    assign load = !v_q || nxt;

    for (genvar g = 0; g < NO; g++) begin : g_mux
      mux4_w #(.WIDTH(WIDTH)) u_mux4 (
        .out  (d_mux[g*WIDTH +: WIDTH]),
        .i00  (d_in[(4*g+0)*WIDTH +: WIDTH]),
        .i01  (d_in[(4*g+1)*WIDTH +: WIDTH]),
        .i10  (d_in[(4*g+2)*WIDTH +: WIDTH]),
        .i11  (d_in[(4*g+3)*WIDTH +: WIDTH]),
        .sel0 (s_in[0]),
        .sel1 (s_in[1])
      );
    end

    // Data only moves on real words; a bubble just clears valid.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (load) begin
        v_q <= v_in;
        if (v_in) d_q <= d_mux;
      end
    end

    if (j < LEVELS - 1) begin : g_sel
      logic [RS-3:0] s_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          s_q <= '0;
        else if (load && v_in) s_q <= s_in[RS-1:2];
      end
    end
  end

  assign in_ready  = lvl[0].load;
  assign out_valid = lvl[LEVELS-1].v_q;
  assign out_data  = lvl[LEVELS-1].d_q;

endmodule

// File: tb/tb_pipe_mux_tree.sv
// Bench for pipe_mux_tree: a 16x8-bit instance for function/flow control and a 64x32-bit one for scaling.
module tb_pipe_mux_tree;

  localparam int AW = 8;
  localparam int AN = 16;
  localparam int AL = 2;
  localparam int BW = 32;
  localparam int BN = 64;
  localparam int BL = 3;

  logic clk = 1'b0;
  logic reset_n;

  logic [AN*AW-1:0] a_in_data;
  logic [2*AL-1:0]  a_in_sel;
  logic             a_in_valid, a_in_ready;
  logic [AW-1:0]    a_out_data;
  logic             a_out_valid, a_out_ready;

  logic [BN*BW-1:0] b_in_data;
  logic [2*BL-1:0]  b_in_sel;
  logic             b_in_valid, b_in_ready;
  logic [BW-1:0]    b_out_data;
  logic             b_out_valid, b_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_mux_tree #(.WIDTH(AW), .N_IN(AN)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  pipe_mux_tree #(.WIDTH(BW), .N_IN(BN)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  function automatic logic [AN*AW-1:0] ramp();
    logic [AN*AW-1:0] v;
    for (int k = 0; k < AN; k++) v[k*AW +: AW] = 8'hA0 + 8'(k);
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    a_in_data = ramp(); a_in_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_data = '0;     b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_in_ready: got %b want 1", a_in_ready); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_out_valid: got %b want 0", a_out_valid); end
    n_checks++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_a_out_data: got %h want 00", a_out_data); end
    n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_in_ready: got %b want 1", b_in_ready); end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid); end
    n_checks++; if (b_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_b_out_data: got %h want 0", b_out_data); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL release_a_out_valid: got %b want 0", a_out_valid); end
    @(negedge clk);
  endtask

  task automatic test_basic_select();
    a_in_data = ramp(); a_in_sel = 4'd11; a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready c%0d: got %b want 1", c, a_in_ready); end
      n_checks++; if (a_out_valid !== (c == 2)) begin n_fail++; $display("FAIL basic_out_valid c%0d: got %b want %b", c, a_out_valid, (c == 2)); end
      if (c == 2) begin
        n_checks++; if (a_out_data !== 8'hAB) begin n_fail++; $display("FAIL basic_out_data: got %h want ab", a_out_data); end
      end
      cyc();
      a_in_valid = 1'b0;
    end
  endtask

  task automatic test_streaming();
    logic [AW-1:0] want;
    a_in_data = ramp(); a_out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      a_in_valid = (c < 16);
      a_in_sel   = 4'(c);
      #1;
      n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c%0d: got %b want 1", c, a_in_ready); end
      n_checks++; if (a_out_valid !== (c >= 2 && c < 18)) begin n_fail++; $display("FAIL stream_out_valid c%0d: got %b want %b", c, a_out_valid, (c >= 2 && c < 18)); end
      if (c >= 2 && c < 18) begin
        want = 8'hA0 + 8'(c - 2);
        n_checks++; if (a_out_data !== want) begin n_fail++; $display("FAIL stream_out_data c%0d: got %h want %h", c, a_out_data, want); end
      end
      cyc();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0]    sels [3] = '{4'd3, 4'd7, 4'd12};
    logic [AW-1:0] q [$];
    logic [AW-1:0] got [$];
    int idx = 0;
    int fv = -1;
    bit stall, exp_rdy;
    a_in_data = ramp();
    for (int c = 0; c < 12; c++) begin
      if (a_out_valid && fv < 0) fv = c;
      stall = (fv >= 0) && (c < fv + 4);
      if (a_out_valid) begin
        n_checks++;
        if (q.size() == 0 || a_out_data !== q[0]) begin n_fail++; $display("FAIL bp_out_data c%0d: got %h want %h (queued %0d)", c, a_out_data, (q.size() > 0) ? q[0] : 8'h00, q.size()); end
      end
      if (stall && c > fv) begin
        n_checks++; if (a_out_data !== 8'hA3 || a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold c%0d: got valid %b data %h want 1 a3", c, a_out_valid, a_out_data); end
      end
      a_in_valid  = (idx < 3);
      a_in_sel    = sels[(idx < 3) ? idx : 0];
      a_out_ready = !stall;
      #1;
      exp_rdy = (q.size() < AL) || a_out_ready;
      n_checks++; if (a_in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want %b", c, a_in_ready, exp_rdy); end
      if (a_out_valid && a_out_ready) begin
        got.push_back(a_out_data);
        if (q.size() > 0) void'(q.pop_front());
      end
      if (a_in_valid && a_in_ready) begin
        q.push_back(a_in_data[int'(a_in_sel)*AW +: AW]);
        idx++;
      end
      cyc();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    n_checks++; if (fv != 2) begin n_fail++; $display("FAIL bp_first_valid: got cycle %0d want 2", fv); end
    n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", got.size()); end
    if (got.size() == 3) begin
      n_checks++; if (got[0] !== 8'hA3 || got[1] !== 8'hA7 || got[2] !== 8'hAC) begin n_fail++; $display("FAIL bp_order: got %h %h %h want a3 a7 ac", got[0], got[1], got[2]); end
    end
  endtask

  task automatic test_pop_push();
    bit            iv   [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic [3:0]    sl   [7] = '{4'd1, 4'd2, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
    bit            ordy [7] = '{0, 0, 1, 0, 1, 1, 1};
    bit            e_ir [7] = '{1, 1, 1, 0, 1, 1, 1};
    bit            e_ov [7] = '{0, 0, 1, 1, 1, 1, 0};
    logic [AW-1:0] e_od [7] = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA2, 8'hA5, 8'h00};
    a_in_data = ramp();
    for (int c = 0; c < 7; c++) begin
      a_in_valid = iv[c]; a_in_sel = sl[c]; a_out_ready = ordy[c];
      #1;
      n_checks++; if (a_in_ready !== e_ir[c]) begin n_fail++; $display("FAIL pp_in_ready c%0d: got %b want %b", c, a_in_ready, e_ir[c]); end
      n_checks++; if (a_out_valid !== e_ov[c]) begin n_fail++; $display("FAIL pp_out_valid c%0d: got %b want %b", c, a_out_valid, e_ov[c]); end
      if (e_ov[c]) begin
        n_checks++; if (a_out_data !== e_od[c]) begin n_fail++; $display("FAIL pp_out_data c%0d: got %h want %h", c, a_out_data, e_od[c]); end
      end
      cyc();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
  endtask

  task automatic test_scaling();
    logic [BW-1:0] want;
    for (int w = 0; w < BN; w++) b_in_data[w*BW +: BW] = $urandom;
    b_in_sel = 6'd45; b_in_valid = 1'b1; b_out_ready = 1'b1;
    want = b_in_data[45*BW +: BW];
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (b_out_valid !== (c == BL)) begin n_fail++; $display("FAIL scale_out_valid c%0d: got %b want %b", c, b_out_valid, (c == BL)); end
      if (c == BL) begin
        n_checks++; if (b_out_data !== want) begin n_fail++; $display("FAIL scale_out_data: got %h want %h", b_out_data, want); end
      end
      cyc();
      b_in_valid = 1'b0;
      for (int w = 0; w < BN; w++) b_in_data[w*BW +: BW] = $urandom;
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] q [$];
    logic [AW-1:0] prev_dat = '0;
    bit prev_hold = 1'b0;
    bit exp_rdy;
    for (int c = 0; c < 320; c++) begin
      if (a_out_valid) begin
        n_checks++;
        if (q.size() == 0 || a_out_data !== q[0]) begin n_fail++; $display("FAIL rand_out_data c%0d: got %h want %h (queued %0d)", c, a_out_data, (q.size() > 0) ? q[0] : 8'h00, q.size()); end
      end
      if (prev_hold) begin
        n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== prev_dat) begin n_fail++; $display("FAIL rand_hold c%0d: got valid %b data %h want 1 %h", c, a_out_valid, a_out_data, prev_dat); end
      end
      for (int w = 0; w < AN*AW/32; w++) a_in_data[w*32 +: 32] = $urandom;
      a_in_sel    = 4'($urandom_range(0, AN - 1));
      a_in_valid  = (c < 300) && ($urandom_range(0, 1) == 1);
      a_out_ready = (c >= 300) || ($urandom_range(0, 9) < 6);
      #1;
      exp_rdy = (q.size() < AL) || a_out_ready;
      n_checks++; if (a_in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready c%0d: got %b want %b", c, a_in_ready, exp_rdy); end
      if (a_out_valid && a_out_ready && q.size() > 0) void'(q.pop_front());
      if (a_in_valid && a_in_ready) q.push_back(a_in_data[int'(a_in_sel)*AW +: AW]);
      prev_hold = a_out_valid && !a_out_ready;
      prev_dat  = a_out_data;
      cyc();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d undelivered want 0", q.size()); end
  endtask

  task automatic test_reset_mid_flight();
    a_in_data = ramp(); a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_sel = 4'd9;
    cyc();
    a_in_sel = 4'd4;
    cyc();
    a_in_valid = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hA9) begin n_fail++; $display("FAIL rmf_pre: got valid %b data %h want 1 a9", a_out_valid, a_out_data); end
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_out_valid: got %b want 0", a_out_valid); end
    n_checks++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL rmf_out_data: got %h want 00", a_out_data); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_in_ready: got %b want 1", a_in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_stale c%0d: got valid %b want 0", c, a_out_valid); end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_basic_select();
    test_streaming();
    test_backpressure();
    test_pop_push();
    test_scaling();
    test_random();
    test_reset_mid_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
